// File: rtl/eb1_axi_gpio_wr_bridge_pkg.sv
// Shared constants, FSM state type and strobe-based lane selection for the
// EB1 AXI write to GPIO bridge.
package eb1_gpio_bridge_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Widest bus the lane selector handles; narrower buses are zero-extended.
  localparam int MAX_LANES = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Lowest 32-bit lane with any strobe bit set; zero when no strobe is set.
  function automatic logic [31:0] sel_lane(
    input logic [MAX_LANES*32-1:0] data,
    input logic [MAX_LANES*4-1:0]  strb
  );
    logic [31:0] word;
    logic        found;
    word  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_LANES; k++) begin
      if (!found && (strb[4*k +: 4] != 4'b0000)) begin
        word  = data[32*k +: 32];
        found = 1'b1;
      end
    end
    return word;
  endfunction

endpackage

// File: rtl/eb1_axi_gpio_wr_bridge_if.sv
// AXI4 write-channel bundle (AW, W, B) between the EB1 LSU and the GPIO bridge.
interface eb1_axi_gpio_wr_bridge_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  // Handshake: a beat transfers on a rising clk edge where valid and ready are
  // both high; valid, once raised, holds with stable payload until that edge.
  logic              awvalid;
  logic              awready;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;

  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic            bvalid;
  logic            bready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;

  modport master (
    output awvalid, awid, awaddr, wvalid, wdata, wstrb, wlast, bready,
    input  awready, wready, bvalid, bid, bresp
  );

  modport slave (
    input  awvalid, awid, awaddr, wvalid, wdata, wstrb, wlast, bready,
    output awready, wready, bvalid, bid, bresp
  );
endinterface

// File: rtl/eb1_axi_gpio_wr_bridge_fifo.sv
// Single-clock synchronous FIFO; read data is valid whenever not empty.
module eb1_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one wrap bit so that full and empty are distinguishable.
  assign level   = wptr_q - rptr_q;
  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign rdata   = mem_q[rptr_q[AW-1:0]];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/eb1_axi_gpio_wr_bridge.sv
// Bridges single-beat EB1 AXI writes onto the Caravel GPIO pads and LA mirror,
// holding each accepted word on the pads for a programmable number of cycles.
module eb1_axi_gpio_wr_bridge
  import eb1_gpio_bridge_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int OUT_W  = 28,
  parameter int DEPTH  = 4,
  parameter int HOLD_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_l,
  eb1_axi_gpio_wr_bridge_if.slave   axi,
  input  logic [ADDR_W-1:0]         win_base,
  input  logic [ADDR_W-1:0]         win_mask,
  input  logic [HOLD_W-1:0]         hold_cycles,
  output logic [OUT_W-1:0]          out_data,
  output logic [OUT_W-1:0]          out_oeb,
  output logic                      out_valid,
  output logic [31:0]               la_word,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output state_t                    fsm_state
);

  logic fifo_full;
  logic fifo_empty;
  logic fifo_push;
  logic fifo_pop;
  logic [31:0] fifo_rdata;
  logic [31:0] push_word;

  logic b_free;
  logic accept;
  logic win_hit;
  logic wr_err;

  logic [MAX_LANES*32-1:0] data_ext;
  logic [MAX_LANES*4-1:0]  strb_ext;

  logic              bvalid_q, bvalid_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic [OUT_W-1:0]  out_oeb_q, out_oeb_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       la_word_q, la_word_d;
  logic              load;
  logic [HOLD_W-1:0] load_cnt;

  always_comb begin
    data_ext                = '0;
    strb_ext                = '0;
    data_ext[DATA_W-1:0]    = axi.wdata;
    strb_ext[DATA_W/8-1:0]  = axi.wstrb;
  end

  // AW and W are taken together, so each ready waits for both valids.
  assign b_free      = ~bvalid_q | axi.bready;
  assign accept      = rst_l & axi.awvalid & axi.wvalid & ~fifo_full & b_free;
  assign axi.awready = accept;
  assign axi.wready  = accept;

  assign win_hit   = ((axi.awaddr & win_mask) == win_base);
  assign wr_err    = ~win_hit | ~axi.wlast;
  assign fifo_push = accept & ~wr_err & (|axi.wstrb);
  assign push_word = sel_lane(data_ext, strb_ext);

  eb1_sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_l (rst_l),
    .push  (fifo_push),
    .wdata (push_word),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    bvalid_d = bvalid_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    if (accept) begin
      bvalid_d = 1'b1;
      bid_d    = axi.awid;
      bresp_d  = wr_err ? RESP_SLVERR : RESP_OKAY;
    end else if (axi.bready) begin
      bvalid_d = 1'b0;
    end
  end

  // A word loads from IDLE, or back-to-back once the current hold expires.
  assign load     = ~fifo_empty & ((state_q == ST_IDLE) || (cnt_q == '0));
  assign fifo_pop = load;
  assign load_cnt = (hold_cycles == '0) ? '0 : hold_cycles - HOLD_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_oeb_d   = out_oeb_q;
    la_word_d   = la_word_q;
    out_valid_d = 1'b0;
    if (load) begin
      state_d     = ST_HOLD;
      cnt_d       = load_cnt;
      out_data_d  = fifo_rdata[OUT_W-1:0];
      la_word_d   = fifo_rdata;
      out_oeb_d   = '0;
      out_valid_d = 1'b1;
    end else if (state_q == ST_HOLD) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - HOLD_W'(1);
      end else begin
        state_d   = ST_IDLE;
        out_oeb_d = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= RESP_OKAY;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_oeb_q   <= '1;
      out_valid_q <= 1'b0;
      la_word_q   <= '0;
    end else begin
      bvalid_q    <= bvalid_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_oeb_q   <= out_oeb_d;
      out_valid_q <= out_valid_d;
      la_word_q   <= la_word_d;
    end
  end

  assign axi.bvalid = bvalid_q;
  assign axi.bid    = bid_q;
  assign axi.bresp  = bresp_q;
  assign out_data   = out_data_q;
  assign out_oeb    = out_oeb_q;
  assign out_valid  = out_valid_q;
  assign la_word    = la_word_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_eb1_axi_gpio_wr_bridge.sv
// Directed bench for eb1_axi_gpio_wr_bridge: vector table plus hand-written
// backpressure, B-stall and reset-mid-hold sequences.
module tb_eb1_axi_gpio_wr_bridge;
  import eb1_gpio_bridge_pkg::*;

  localparam int DATA_W = 64;
  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int OUT_W  = 28;
  localparam int DEPTH  = 4;
  localparam int HOLD_W = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] win_base;
  logic [ADDR_W-1:0] win_mask;
  logic [HOLD_W-1:0] hold_cycles;
  logic [OUT_W-1:0]  out_data;
  logic [OUT_W-1:0]  out_oeb;
  logic              out_valid;
  logic [31:0]       la_word;
  logic [$clog2(DEPTH):0] fifo_level;
  state_t            fsm_state;

  eb1_axi_gpio_wr_bridge_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  eb1_axi_gpio_wr_bridge #(
    .DATA_W(DATA_W), .ID_W(ID_W), .ADDR_W(ADDR_W),
    .OUT_W(OUT_W), .DEPTH(DEPTH), .HOLD_W(HOLD_W)
  ) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .axi         (axi),
    .win_base    (win_base),
    .win_mask    (win_mask),
    .hold_cycles (hold_cycles),
    .out_data    (out_data),
    .out_oeb     (out_oeb),
    .out_valid   (out_valid),
    .la_word     (la_word),
    .fifo_level  (fifo_level),
    .fsm_state   (fsm_state)
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];
  localparam logic [63:0] OEB_OFF = 64'((1 << OUT_W) - 1);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_write(input logic [31:0] addr, input logic [63:0] data,
                             input logic [7:0] strb, input logic last, input logic [3:0] id);
    int waited;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    axi.awaddr  = addr;
    axi.awid    = id;
    axi.wdata   = data;
    axi.wstrb   = strb;
    axi.wlast   = last;
    waited = 0;
    @(negedge clk);
    while (!axi.awready && waited < 300) begin
      waited++;
      @(negedge clk);
    end
    check("accept_in_time", 64'(waited < 300), 64'(1));
    @(posedge clk);
    #1;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic [15:0] hold;
    logic [1:0]  exp_resp;
    logic        exp_push;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[8];

  // ---------------- main test ----------------
  initial begin
    int held, seen, stall_seen, pulses, cyc, last_cyc, max_lvl, acc_cnt, bid_chg, h;
    logic [31:0] word;

    vecs[0] = '{32'hD000_0000, 64'h0000_0000_0ABC_DEF1, 8'h0F, 1'b1, 16'd3, RESP_OKAY,   1'b1, 32'h0ABC_DEF1};
    vecs[1] = '{32'hD000_0010, 64'h1234_5678_DEAD_BEEF, 8'hF0, 1'b1, 16'd2, RESP_OKAY,   1'b1, 32'h1234_5678};
    vecs[2] = '{32'h3000_0000, 64'h0000_0000_1111_1111, 8'h0F, 1'b1, 16'd2, RESP_SLVERR, 1'b0, 32'h0};
    vecs[3] = '{32'hD000_0000, 64'h0000_0000_2222_2222, 8'h0F, 1'b0, 16'd2, RESP_SLVERR, 1'b0, 32'h0};
    vecs[4] = '{32'hD000_0000, 64'h3333_3333_3333_3333, 8'h00, 1'b1, 16'd2, RESP_OKAY,   1'b0, 32'h0};
    vecs[5] = '{32'hD000_0100, 64'hFFFF_FFFF_8765_4321, 8'h01, 1'b1, 16'd0, RESP_OKAY,   1'b1, 32'h8765_4321};
    vecs[6] = '{32'hD000_0200, 64'hCAFE_F00D_1111_2222, 8'h30, 1'b1, 16'd1, RESP_OKAY,   1'b1, 32'hCAFE_F00D};
    vecs[7] = '{32'hDFFF_FFFC, 64'hAAAA_AAAA_0000_0001, 8'h81, 1'b1, 16'd4, RESP_OKAY,   1'b1, 32'h0000_0001};

    win_base    = 32'hD000_0000;
    win_mask    = 32'hF000_0000;
    hold_cycles = 16'd1;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    axi.awid    = 4'h3;
    axi.awaddr  = 32'hD000_0000;
    axi.wdata   = 64'h1;
    axi.wstrb   = 8'h0F;
    axi.wlast   = 1'b1;
    axi.bready  = 1'b1;

    // Reset values, with valids held high so ready gating is exercised.
    repeat (2) @(posedge clk);
    #1;
    check("rst_awready",  64'(axi.awready), 64'(0));
    check("rst_wready",   64'(axi.wready),  64'(0));
    check("rst_bvalid",   64'(axi.bvalid),  64'(0));
    check("rst_bid",      64'(axi.bid),     64'(0));
    check("rst_bresp",    64'(axi.bresp),   64'(0));
    check("rst_out_data", 64'(out_data),    64'(0));
    check("rst_out_oeb",  64'(out_oeb),     OEB_OFF);
    check("rst_out_valid",64'(out_valid),   64'(0));
    check("rst_la_word",  64'(la_word),     64'(0));
    check("rst_level",    64'(fifo_level),  64'(0));
    check("rst_state",    64'(fsm_state),   64'(ST_IDLE));
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    rst_l = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Table-driven single writes.
    for (int i = 0; i < 8; i++) begin
      hold_cycles = vecs[i].hold;
      h = (vecs[i].hold == 16'd0) ? 1 : int'(vecs[i].hold);
      drive_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].last, 4'(i));
      check($sformatf("v%0d_bvalid", i), 64'(axi.bvalid), 64'(1));
      check($sformatf("v%0d_bid", i),    64'(axi.bid),    64'(i));
      check($sformatf("v%0d_bresp", i),  64'(axi.bresp),  64'(vecs[i].exp_resp));
      check($sformatf("v%0d_level", i),  64'(fifo_level), 64'(vecs[i].exp_push));
      if (vecs[i].exp_push) begin
        word = vecs[i].exp_word;
        @(posedge clk); #1;
        check($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(1));
        check($sformatf("v%0d_out_data", i),  64'(out_data),  64'(word[OUT_W-1:0]));
        check($sformatf("v%0d_la_word", i),   64'(la_word),   64'(word));
        check($sformatf("v%0d_oeb_on", i),    64'(out_oeb),   64'(0));
        held = 1;
        seen = 0;
        while (held < 300) begin
          @(posedge clk); #1;
          if (out_valid) seen++;
          if (out_oeb != '0) break;
          held++;
        end
        check($sformatf("v%0d_hold_len", i),  64'(held),     64'(h));
        check($sformatf("v%0d_extra_pulse", i), 64'(seen),   64'(0));
        check($sformatf("v%0d_oeb_off", i),   64'(out_oeb),  OEB_OFF);
        check($sformatf("v%0d_data_kept", i), 64'(out_data), 64'(word[OUT_W-1:0]));
      end else begin
        seen = 0;
        repeat (6) begin
          @(posedge clk); #1;
          if (out_valid) seen++;
        end
        check($sformatf("v%0d_no_out_valid", i), 64'(seen),       64'(0));
        check($sformatf("v%0d_level_zero", i),   64'(fifo_level), 64'(0));
      end
    end

    // Backpressure: six back-to-back writes against a 4-deep FIFO, hold 100.
    hold_cycles = 16'd100;
    exp_q.delete();
    stall_seen = 0;
    pulses = 0;
    max_lvl = 0;
    fork
      begin
        int waited;
        for (int i = 0; i < 6; i++) begin
          word = 32'h5A00_0000 | 32'(i * 32'h0001_0101);
          axi.awvalid = 1'b1;
          axi.wvalid  = 1'b1;
          axi.awaddr  = 32'hD000_0000;
          axi.awid    = 4'(i);
          axi.wdata   = {32'hFFFF_FFFF, word};
          axi.wstrb   = 8'h0F;
          axi.wlast   = 1'b1;
          waited = 0;
          @(negedge clk);
          while (!axi.awready && waited < 1000) begin
            stall_seen++;
            waited++;
            @(negedge clk);
          end
          @(posedge clk);
          exp_q.push_back(word);
          #1;
        end
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
      end
      begin
        cyc = 0;
        last_cyc = 0;
        while (pulses < 6 && cyc < 1500) begin
          @(posedge clk); #1;
          cyc++;
          if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
          if (out_valid) begin
            if (exp_q.size() == 0) check("bp_queue_nonempty", 64'(0), 64'(1));
            else check($sformatf("bp_word%0d", pulses), 64'(la_word), 64'(exp_q.pop_front()));
            if (pulses > 0) check($sformatf("bp_spacing%0d", pulses), 64'(cyc - last_cyc), 64'(100));
            last_cyc = cyc;
            pulses++;
          end
        end
      end
    join
    check("bp_stall_seen", 64'(stall_seen > 0), 64'(1));
    check("bp_pulses",     64'(pulses),         64'(6));
    check("bp_max_level",  64'(max_lvl),        64'(DEPTH));
    held = 0;
    while (out_oeb != OEB_OFF[OUT_W-1:0] && held < 300) begin
      @(posedge clk); #1;
      held++;
    end
    check("bp_drained_oeb", 64'(out_oeb), OEB_OFF);

    // B stall: pending response with bready low blocks further accepts.
    hold_cycles = 16'd1;
    axi.bready  = 1'b0;
    drive_write(32'hD000_0000, 64'h0000_0000_0000_00A5, 8'h0F, 1'b1, 4'h5);
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    axi.awid    = 4'hA;
    axi.wdata   = 64'h0000_0000_0000_00B6;
    acc_cnt = 0;
    bid_chg = 0;
    repeat (10) begin
      @(negedge clk);
      if (axi.awready) acc_cnt++;
      if (axi.bid != 4'h5 || !axi.bvalid) bid_chg++;
    end
    check("bstall_no_accept", 64'(acc_cnt), 64'(0));
    check("bstall_bid_stable", 64'(bid_chg), 64'(0));
    @(posedge clk); #1;
    axi.bready = 1'b1;
    @(negedge clk);
    check("bstall_accept_on_bready", 64'(axi.awready), 64'(1));
    @(posedge clk); #1;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    check("bstall_new_bvalid", 64'(axi.bvalid), 64'(1));
    check("bstall_new_bid",    64'(axi.bid),    64'(4'hA));
    repeat (10) @(posedge clk);
    #1;
    check("bstall_drained_level", 64'(fifo_level), 64'(0));
    check("bstall_la_word",       64'(la_word),    64'(32'h0000_00B6));

    // Reset in the middle of a hold with two words queued and B pending.
    hold_cycles = 16'd50;
    axi.bready  = 1'b1;
    drive_write(32'hD000_0000, 64'h0000_0000_0000_0C01, 8'h0F, 1'b1, 4'h1);
    drive_write(32'hD000_0000, 64'h0000_0000_0000_0C02, 8'h0F, 1'b1, 4'h2);
    drive_write(32'hD000_0000, 64'h0000_0000_0000_0C03, 8'h0F, 1'b1, 4'h3);
    axi.bready = 1'b0;
    check("rmh_pre_level",  64'(fifo_level), 64'(2));
    check("rmh_pre_oeb",    64'(out_oeb),    64'(0));
    check("rmh_pre_bvalid", 64'(axi.bvalid), 64'(1));
    rst_l = 1'b0;
    @(posedge clk); #1;
    check("rmh_oeb",    64'(out_oeb),    OEB_OFF);
    check("rmh_bvalid", 64'(axi.bvalid), 64'(0));
    check("rmh_level",  64'(fifo_level), 64'(0));
    check("rmh_state",  64'(fsm_state),  64'(ST_IDLE));
    rst_l = 1'b1;
    axi.bready = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("rmh_no_out_valid", 64'(seen),    64'(0));
    check("rmh_oeb_stays",    64'(out_oeb), OEB_OFF);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
